mem_bus_responder: RTL and testbench

Memory-side responder for the CPU's memory bus. The control sequencer issues word (16-bit) fetch, load and store requests over a req/ack handshake. This block accepts each request, inserts a configurable number of wait states, and performs the access as two little-endian byte accesses on an internal 16Ki x 8 byte RAM. It replaces direct wiring of the control unit to main memory and gives the CPU deterministic, handshaked memory timing.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/byte_ram.sv | 23 ++
 rtl/mem_bus_responder.sv | 133 +++++++++++++
 tb/tb_mem_bus_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: bus widths, default RAM depth and responder FSM states.
// Imported by the responder, its byte RAM and the CPU control sequencer.
package mem_bus_pkg;

  localparam int unsigned DataWidth        = 16;
  localparam int unsigned BusAddrWidth     = 16;
  localparam int unsigned DefaultAddrWidth = 14;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StWait = 3'd1;
  localparam state_t StLo   = 3'd2;
  localparam state_t StHi   = 3'd3;
  localparam state_t StResp = 3'd4;

endpackage

// File: rtl/byte_ram.sv
// Single-port byte RAM: synchronous write, one-cycle synchronous read (read-before-write).
module byte_ram
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout
);

  logic [7:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout <= mem_q[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Handshaked word responder: accepts a request, waits WAIT_STATES cycles, then does two
// little-endian byte accesses. Define MEM_BUS_ERR_EN to flag and suppress out-of-range accesses.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [BusAddrWidth-1:0] addr,
  input  logic [DataWidth-1:0]    wdata,
  output logic                    ack,
  output logic [DataWidth-1:0]    rdata,
  output logic                    busy
`ifdef MEM_BUS_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam logic [3:0] WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [BusAddrWidth-1:0] addr_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [7:0]              lo_q;
  logic [DataWidth-1:0]    rdata_q;

  logic                    addr_err;
  logic [ADDR_WIDTH-1:0]   ram_lo_addr;
  logic [ADDR_WIDTH-1:0]   ram_hi_addr;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    ram_we;
  logic [7:0]              ram_din;
  logic [7:0]              ram_dout;

`ifdef MEM_BUS_ERR_EN
  assign addr_err = |(addr_q >> ADDR_WIDTH);
  assign err      = (state_q == StResp) && addr_err;
`else
  // Upper address bits alias onto the RAM when error checking is compiled out.
  logic unused_addr_hi;
  assign unused_addr_hi = |(addr_q >> ADDR_WIDTH);
  assign addr_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = (WAIT_STATES == 0) ? StLo : StWait;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StLo;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StLo:    state_d = StHi;
      StHi:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ram_lo_addr = addr_q[ADDR_WIDTH-1:0];
  assign ram_hi_addr = ram_lo_addr + ADDR_WIDTH'(1);
  assign ram_addr    = (state_q == StHi) ? ram_hi_addr : ram_lo_addr;
  assign ram_din     = (state_q == StHi) ? wdata_q[15:8] : wdata_q[7:0];
  assign ram_we      = ((state_q == StLo) || (state_q == StHi)) && we_q && !addr_err;

  byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_byte_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign ack  = (state_q == StResp);
  assign busy = (state_q != StIdle);

  // High byte arrives from the RAM in the ack cycle itself, so rdata is assembled there.
  always_comb begin
    rdata = rdata_q;
    if (state_q == StResp) begin
      if (addr_err) begin
        rdata = '0;
      end else if (!we_q) begin
        rdata = {ram_dout, lo_q};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= 8'h00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == StIdle) && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == StHi) begin
        lo_q <= ram_dout;
      end
      if ((state_q == StResp) && !we_q) begin
        rdata_q <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two instances (WAIT_STATES 0 and 1) checked every cycle against
// a transaction-level model, plus directed transactions with literal expectations.
module tb_mem_bus_responder;

  localparam int unsigned AW = 14;
`ifdef MEM_BUS_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic        ack   [2];
  logic [15:0] rdata [2];
  logic        busy  [2];
  logic        err_w [2];

  always #5 clock = ~clock;

  mem_bus_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_STATES(0)
  ) u_dut0 (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req[0]),
    .we     (we[0]),
    .addr   (addr[0]),
    .wdata  (wdata[0]),
    .ack    (ack[0]),
    .rdata  (rdata[0]),
    .busy   (busy[0])
`ifdef MEM_BUS_ERR_EN
    ,
    .err    (err_w[0])
`endif
  );

  mem_bus_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_STATES(1)
  ) u_dut1 (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req[1]),
    .we     (we[1]),
    .addr   (addr[1]),
    .wdata  (wdata[1]),
    .ack    (ack[1]),
    .rdata  (rdata[1]),
    .busy   (busy[1])
`ifdef MEM_BUS_ERR_EN
    ,
    .err    (err_w[1])
`endif
  );

`ifndef MEM_BUS_ERR_EN
  assign err_w[0] = 1'b0;
  assign err_w[1] = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: byte memory with known flags, one pending transaction per instance.
  logic [7:0]  m_mem [2][1<<AW];
  bit          m_kn  [2][1<<AW];
  bit          pend  [2];
  int          acc   [2];
  int          ackc  [2];
  bit          t_we  [2];
  logic [15:0] t_addr  [2];
  logic [15:0] t_wdata [2];
  logic [15:0] h_rd [2];
  logic [1:0]  h_kn [2];

  logic [15:0] b2b_addr [3] = '{16'h0200, 16'h0202, 16'h0204};
  logic [15:0] b2b_exp  [3] = '{16'h1111, 16'h2222, 16'h3333};

  function automatic int ws(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp, logic [15:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h (mask %h)",
               name, d, cyc, act, exp, mask);
    end
  endtask

  task automatic step(int d);
    bit          e_ack, e_busy, e_err, oor;
    logic [15:0] e_rd;
    logic [1:0]  e_kn;
    logic [13:0] a0, a1;
    if (!reset_n) begin
      // A store whose low-byte cycle already completed keeps that byte.
      if (pend[d] && t_we[d] && (cyc > acc[d] + ws(d) + 1) &&
          !(ErrEn && (t_addr[d][15:14] != 2'b00))) begin
        a0 = t_addr[d][13:0];
        m_mem[d][a0] = t_wdata[d][7:0];
        m_kn[d][a0]  = 1'b1;
      end
      pend[d] = 1'b0;
      h_rd[d] = 16'h0000;
      h_kn[d] = 2'b11;
    end
    e_ack  = pend[d] && (cyc == ackc[d]);
    e_busy = pend[d] && (cyc > acc[d]);
    e_err  = 1'b0;
    e_rd   = h_rd[d];
    e_kn   = h_kn[d];
    if (e_ack) begin
      a0  = t_addr[d][13:0];
      a1  = a0 + 14'd1;
      oor = ErrEn && (t_addr[d][15:14] != 2'b00);
      if (oor) begin
        e_err = 1'b1;
        e_rd  = 16'h0000;
        e_kn  = 2'b11;
      end else if (t_we[d]) begin
        m_mem[d][a0] = t_wdata[d][7:0];
        m_mem[d][a1] = t_wdata[d][15:8];
        m_kn[d][a0]  = 1'b1;
        m_kn[d][a1]  = 1'b1;
      end else begin
        e_rd = {m_mem[d][a1], m_mem[d][a0]};
        e_kn = {m_kn[d][a1], m_kn[d][a0]};
      end
      if (!t_we[d]) begin
        h_rd[d] = e_rd;
        h_kn[d] = e_kn;
      end
    end
    chk("ack", d, {15'b0, ack[d]}, {15'b0, e_ack}, 16'h0001);
    chk("busy", d, {15'b0, busy[d]}, {15'b0, e_busy}, 16'h0001);
    chk("rdata", d, rdata[d], e_rd, {{8{e_kn[1]}}, {8{e_kn[0]}}});
    chk("err", d, {15'b0, err_w[d]}, {15'b0, e_err}, 16'h0001);
    if (e_ack) begin
      pend[d] = 1'b0;
    end else if (reset_n && !pend[d] && req[d]) begin
      pend[d]    = 1'b1;
      acc[d]     = cyc;
      ackc[d]    = cyc + ws(d) + 3;
      t_we[d]    = we[d];
      t_addr[d]  = addr[d];
      t_wdata[d] = wdata[d];
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) step(d);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Issue one request; inputs are scrambled right after acceptance to show they are ignored.
  task automatic do_txn(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output logic e);
    lat = -1;
    rd  = 16'hxxxx;
    e   = 1'bx;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    sync();
    req[d] = 1'b0; we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clock);
      if (ack[d]) begin
        lat = n;
        rd  = rdata[d];
        e   = err_w[d];
        sync();
        break;
      end
      sync();
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout dut%0d addr %h: got no ack expected ack within 24 cycles", d, a);
    end
  endtask

  initial begin
    int          lat, k, last;
    logic [15:0] rd;
    logic        e;
    bit          seen;

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = 16'h0000; wdata[d] = 16'h0000;
    end
    repeat (3) sync();
    reset_n = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (2) sync();
    @(negedge clock);
    chk("reset_rdata", 0, rdata[0], 16'h0000, 16'hffff);
    chk("reset_busy", 1, {15'b0, busy[1]}, 16'h0000, 16'h0001);
    sync();

    // Store then load with one wait state.
    do_txn(1, 1'b1, 16'h0010, 16'hBEEF, lat, rd, e);
    chk("store_latency", 1, 16'(lat), 16'd4, 16'hffff);
    do_txn(1, 1'b1, 16'h0012, 16'h0000, lat, rd, e);
    do_txn(1, 1'b0, 16'h0010, 16'h0000, lat, rd, e);
    chk("load_latency", 1, 16'(lat), 16'd4, 16'hffff);
    chk("load_beef", 1, rd, 16'hBEEF, 16'hffff);
    do_txn(1, 1'b0, 16'h0011, 16'h0000, lat, rd, e);
    chk("load_odd", 1, rd, 16'h00BE, 16'hffff);

    // High byte of a word at the top of memory wraps to address 0.
    do_txn(1, 1'b1, 16'h3FFF, 16'h1234, lat, rd, e);
    do_txn(1, 1'b0, 16'h0000, 16'h0000, lat, rd, e);
    chk("wrap_lo", 1, rd, 16'h0012, 16'h00ff);
    do_txn(1, 1'b0, 16'h3FFE, 16'h0000, lat, rd, e);
    chk("wrap_top", 1, rd, 16'h3400, 16'hff00);

    // Zero wait states: preload, then three loads with req held across ack.
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b1, b2b_addr[i], b2b_exp[i], lat, rd, e);
      chk("ws0_latency", 0, 16'(lat), 16'd3, 16'hffff);
    end
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = b2b_addr[0];
    k = 0;
    last = -1;
    for (int n = 0; n < 64 && k < 3; n++) begin
      @(negedge clock);
      seen = ack[0];
      if (seen) begin
        chk("b2b_rdata", 0, rdata[0], b2b_exp[k], 16'hffff);
        if (last >= 0) chk("b2b_spacing", 0, 16'(n - last), 16'd4, 16'hffff);
        last = n;
        k++;
      end
      sync();
      if (seen) begin
        if (k < 3) addr[0] = b2b_addr[k];
        else req[0] = 1'b0;
      end
    end
    req[0] = 1'b0;
    if (k < 3) begin
      checks++;
      failures++;
      $display("FAIL b2b_timeout dut0: got %0d acks expected 3", k);
    end

    // Reset during the high-byte cycle of a store.
    do_txn(1, 1'b1, 16'h0100, 16'h7700, lat, rd, e);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0100; wdata[1] = 16'hA55A;
    sync();
    req[1] = 1'b0;
    sync();
    sync();
    reset_n = 1'b0;
    repeat (2) sync();
    reset_n = 1'b1;
    sync();
    do_txn(1, 1'b0, 16'h0100, 16'h0000, lat, rd, e);
    chk("reset_mid_store", 1, rd, 16'h775A, 16'hffff);

`ifdef MEM_BUS_ERR_EN
    do_txn(1, 1'b1, 16'h0000, 16'h5678, lat, rd, e);
    do_txn(1, 1'b1, 16'h8000, 16'hCAFE, lat, rd, e);
    chk("err_store_latency", 1, 16'(lat), 16'd4, 16'hffff);
    chk("err_store_flag", 1, {15'b0, e}, 16'h0001, 16'h0001);
    do_txn(1, 1'b0, 16'h8000, 16'h0000, lat, rd, e);
    chk("err_load_latency", 1, 16'(lat), 16'd4, 16'hffff);
    chk("err_load_flag", 1, {15'b0, e}, 16'h0001, 16'h0001);
    chk("err_load_rdata", 1, rd, 16'h0000, 16'hffff);
    do_txn(1, 1'b0, 16'h0000, 16'h0000, lat, rd, e);
    chk("err_no_write", 1, rd, 16'h5678, 16'hffff);
    chk("err_clear", 1, {15'b0, e}, 16'h0000, 16'h0001);
`else
    do_txn(1, 1'b1, 16'h4020, 16'hCAFE, lat, rd, e);
    do_txn(1, 1'b0, 16'h0020, 16'h0000, lat, rd, e);
    chk("alias_load", 1, rd, 16'hCAFE, 16'hffff);
`endif

    repeat (4) sync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
